btn_event_encoder: RTL and testbench

BTN_EVENT_ENCODER -- requirements
Module: btn_event_encoder

---
 rtl/btn_evt_pkg.sv | 13 +
 rtl/btn_evt_fifo.sv | 53 +++++
 rtl/btn_event_encoder.sv | 115 +++++++++++
 tb/tb_btn_event_encoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared event-type encodings and index-width helper for the button event encoder.
package btn_evt_pkg;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_LONG    = 2'b11;

  function automatic int idx_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// First-word-fall-through event queue; head reads as zero while empty.
module btn_evt_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic              full,
  output logic [DATA_W-1:0] head
);

  localparam int PTRW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic [CNTW-1:0]   count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign valid   = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head mux hides stale words while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btn_event_encoder.sv
// Turns debounced button levels into queued PRESS / RELEASE / LONG events,
// lowest button index first, with a sticky flag for overwritten events.
module btn_event_encoder
  import btn_evt_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int LONG_CNT   = 50_000_000,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDXW       = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_lvl,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDXW-1:0]  evt_idx,
  output logic [1:0]       evt_type,
  output logic             evt_ovf
);

  localparam int              CNTW      = $clog2(LONG_CNT + 1);
  localparam logic [CNTW-1:0] LONG_MAX  = CNTW'(LONG_CNT);
  localparam logic [CNTW-1:0] LONG_LAST = CNTW'(LONG_CNT - 1);

  logic [WIDTH-1:0] lvl_q;
  logic [1:0]       pending  [WIDTH];
  logic [CNTW-1:0]  hold_cnt [WIDTH];
  logic [1:0]       new_evt  [WIDTH];
  logic [WIDTH-1:0] clr;
  logic             ovf_hit;
  logic             any_pend;
  logic [IDXW-1:0]  sel_idx;
  logic [1:0]       sel_type;
  logic             push;
  logic             fifo_full;

  // Event detection: edges against the registered level, LONG on the count-up into LONG_CNT.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      new_evt[i] = EVT_NONE;
      if (!btn_lvl[i] && lvl_q[i])
        new_evt[i] = EVT_RELEASE;
      else if (btn_lvl[i] && hold_cnt[i] == LONG_LAST)
        new_evt[i] = EVT_LONG;
      else if (btn_lvl[i] && !lvl_q[i])
        new_evt[i] = EVT_PRESS;
    end
  end

  // Fixed-priority arbiter: descending scan so the lowest pending index wins.
  always_comb begin
    any_pend = 1'b0;
    sel_idx  = '0;
    sel_type = EVT_NONE;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i] != EVT_NONE) begin
        any_pend = 1'b1;
        sel_idx  = IDXW'(i);
        sel_type = pending[i];
      end
    end
  end

  assign push = any_pend && !fifo_full;

  always_comb begin
    ovf_hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      clr[i] = push && (sel_idx == IDXW'(i));
      if (new_evt[i] != EVT_NONE && pending[i] != EVT_NONE && !clr[i])
        ovf_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q   <= '0;
      evt_ovf <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        pending[i]  <= EVT_NONE;
        hold_cnt[i] <= '0;
      end
    end else begin
      lvl_q <= btn_lvl;
      if (ovf_hit) evt_ovf <= 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        // A fresh event beats the clear of the entry being pushed this edge.
        if (new_evt[i] != EVT_NONE)
          pending[i] <= new_evt[i];
        else if (clr[i])
          pending[i] <= EVT_NONE;

        if (!btn_lvl[i])
          hold_cnt[i] <= '0;
        else if (hold_cnt[i] != LONG_MAX)
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

  btn_evt_fifo #(
    .DATA_W (IDXW + 2),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({sel_idx, sel_type}),
    .pop       (evt_ready),
    .valid     (evt_valid),
    .full      (fifo_full),
    .head      ({evt_idx, evt_type})
  );

endmodule

// File: tb/tb_btn_event_encoder.sv
// Directed bench for btn_event_encoder with LONG_CNT = 16 and FIFO_DEPTH = 4.
module tb_btn_event_encoder;
  import btn_evt_pkg::*;

  localparam int WIDTH = 8;
  localparam int IDXW  = idx_w(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] btn_lvl;
  logic             evt_ready;
  logic             evt_valid;
  logic [IDXW-1:0]  evt_idx;
  logic [1:0]       evt_type;
  logic             evt_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_event_encoder #(
    .WIDTH      (WIDTH),
    .LONG_CNT   (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_lvl   (btn_lvl),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_idx   (evt_idx),
    .evt_type  (evt_type),
    .evt_ovf   (evt_ovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ev_cyc [3];
  int ev_idx [3];
  int ev_typ [3];
  int n_ev;

  initial begin
    rst_n     = 1'b0;
    btn_lvl   = '0;
    evt_ready = 1'b0;
    step();
    step();
    chk("rst_valid", evt_valid, 0);
    chk("rst_idx", evt_idx, 0);
    chk("rst_type", evt_type, 0);
    chk("rst_ovf", evt_ovf, 0);
    rst_n = 1'b1;
    step();

    // Single press, latency check.
    evt_ready = 1'b1;
    btn_lvl   = 8'h04;
    step();
    chk("lat_edge_k_valid", evt_valid, 0);
    step();
    chk("lat_edge_k1_valid", evt_valid, 1);
    chk("lat_idx", evt_idx, 2);
    chk("lat_type", evt_type, 1);
    step();
    chk("lat_popped", evt_valid, 0);
    btn_lvl = 8'h00;
    for (int c = 0; c < 4; c++) step();
    chk("lat_rel_drained", evt_valid, 0);

    // Long press on button 3 held 20 cycles.
    n_ev    = 0;
    btn_lvl = 8'h08;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 20) btn_lvl = 8'h00;
      if (evt_valid) begin
        if (n_ev < 3) begin
          ev_cyc[n_ev] = c;
          ev_idx[n_ev] = int'(evt_idx);
          ev_typ[n_ev] = int'(evt_type);
        end
        n_ev++;
      end
    end
    chk("long_nev", n_ev, 3);
    chk("long_press_cyc", ev_cyc[0], 2);
    chk("long_press_idx", ev_idx[0], 3);
    chk("long_press_type", ev_typ[0], 1);
    chk("long_long_cyc", ev_cyc[1], 17);
    chk("long_long_idx", ev_idx[1], 3);
    chk("long_long_type", ev_typ[1], 3);
    chk("long_rel_cyc", ev_cyc[2], 22);
    chk("long_rel_idx", ev_idx[2], 3);
    chk("long_rel_type", ev_typ[2], 2);
    chk("long_ovf", evt_ovf, 0);

    // Simultaneous presses on 0 and 7: lowest index first.
    btn_lvl = 8'h81;
    step();
    step();
    chk("pri_first_valid", evt_valid, 1);
    chk("pri_first_idx", evt_idx, 0);
    chk("pri_first_type", evt_type, 1);
    step();
    chk("pri_second_valid", evt_valid, 1);
    chk("pri_second_idx", evt_idx, 7);
    chk("pri_second_type", evt_type, 1);
    btn_lvl = 8'h00;
    for (int c = 0; c < 6; c++) step();
    chk("pri_drained", evt_valid, 0);

    // Overflow: six press/release pairs with the consumer stalled.
    evt_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      btn_lvl = 8'(1 << j);
      step();
      btn_lvl = 8'h00;
      step();
      step();
    end
    chk("ovf_set", evt_ovf, 1);
    chk("ovf_valid", evt_valid, 1);
    begin
      int exp_idx [4] = '{0, 0, 1, 1};
      int exp_typ [4] = '{1, 2, 1, 2};
      step();
      chk("ovf_hold_idx", evt_idx, 0);
      chk("ovf_hold_type", evt_type, 1);
      evt_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("ovf_drain%0d_idx", n), evt_idx, exp_idx[n]);
        chk($sformatf("ovf_drain%0d_type", n), evt_type, exp_typ[n]);
        step();
      end
    end
    for (int c = 0; c < 12; c++) step();
    chk("ovf_empty", evt_valid, 0);
    chk("ovf_sticky", evt_ovf, 1);

    // Mid-operation reset with three events queued.
    evt_ready = 1'b0;
    btn_lvl   = 8'h07;
    step();
    for (int c = 0; c < 4; c++) step();
    chk("mrst_pre_valid", evt_valid, 1);
    chk("mrst_pre_idx", evt_idx, 0);
    btn_lvl   = 8'h00;
    rst_n     = 1'b0;
    evt_ready = 1'b1;
    step();
    chk("mrst_valid", evt_valid, 0);
    chk("mrst_ovf", evt_ovf, 0);
    chk("mrst_idx", evt_idx, 0);
    rst_n = 1'b1;
    n_ev  = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (evt_valid) n_ev++;
    end
    chk("mrst_no_stale", n_ev, 0);

    // Button held through reset release.
    rst_n   = 1'b0;
    btn_lvl = 8'h10;
    step();
    rst_n = 1'b1;
    step();
    chk("hold_rst_edge1_valid", evt_valid, 0);
    step();
    chk("hold_rst_edge2_valid", evt_valid, 1);
    chk("hold_rst_idx", evt_idx, 4);
    chk("hold_rst_type", evt_type, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
